booth_r16_seq_mul: RTL

- Iterative radix-16 Booth multiplier core. It consumes one multiplier digit (booth_sel_t) per cycle from the shared package.
- Accepts a WIDTH x WIDTH operand pair over a valid/ready handshake.
- Precomputes the odd multiples of the multiplicand, then scans the multiplier four bits at a time. Each digit is encoded into a booth_sel_t, the matching partial product is selected, and it is accumulated.
- Sits between the operand-issue logic and the result writeback. It is the area-optimised alternative to the parallel partial-product array.

---
 rtl/booth_r16_pkg.sv | 62 ++++++
 rtl/booth_r16_pp_sel.sv | 48 ++++
 rtl/booth_r16_seq_mul.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/booth_r16_pkg.sv
// Shared definitions for the radix-16 Booth multipliers: digit select encoding,
// sequencer state encoding and the window-to-digit encoder.
package booth_r16_pkg;

  localparam int DIGIT_BITS  = 4;
  localparam int WINDOW_BITS = DIGIT_BITS + 1;

  typedef enum logic [4:0] {
    PP_0,
    PP_1A,
    PP_2A,
    PP_3A,
    PP_4A,
    PP_5A,
    PP_6A,
    PP_7A,
    PP_8A,
    PP_not1A,
    PP_not2A,
    PP_not3A,
    PP_not4A,
    PP_not5A,
    PP_not6A,
    PP_not7A,
    PP_not8A
  } booth_sel_t;

  typedef enum logic [1:0] {
    IDLE,
    PRECOMP,
    ITER,
    DONE
  } mul_state_t;

  // Window bit 4 is the digit MSB (weight -8), bit 0 is the borrow-in from below.
  function automatic booth_sel_t booth_r16_encode(input logic [WINDOW_BITS-1:0] w);
    int         d;
    booth_sel_t sel;
    d = -8 * int'(w[4]) + 4 * int'(w[3]) + 2 * int'(w[2]) + int'(w[1]) + int'(w[0]);
    case (d)
      1:       sel = PP_1A;
      2:       sel = PP_2A;
      3:       sel = PP_3A;
      4:       sel = PP_4A;
      5:       sel = PP_5A;
      6:       sel = PP_6A;
      7:       sel = PP_7A;
      8:       sel = PP_8A;
      -1:      sel = PP_not1A;
      -2:      sel = PP_not2A;
      -3:      sel = PP_not3A;
      -4:      sel = PP_not4A;
      -5:      sel = PP_not5A;
      -6:      sel = PP_not6A;
      -7:      sel = PP_not7A;
      -8:      sel = PP_not8A;
      default: sel = PP_0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_r16_pp_sel.sv
// Radix-16 partial-product selector: picks k*A (k = -8..8) from A and the
// precomputed odd multiples; even multiples are shifts of A or 3A.
module booth_r16_pp_sel
  import booth_r16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  booth_sel_t               i_sel,
  input  logic signed [WIDTH+3:0]  i_a1,
  input  logic signed [WIDTH+3:0]  i_a3,
  input  logic signed [WIDTH+3:0]  i_a5,
  input  logic signed [WIDTH+3:0]  i_a7,
  output logic signed [WIDTH+3:0]  o_pp
);

  localparam int PW = WIDTH + 4;

  logic signed [PW-1:0] w_mag;
  logic                 w_neg;

  always_comb begin
    w_mag = '0;
    w_neg = 1'b0;
    case (i_sel)
      PP_1A:    w_mag = i_a1;
      PP_2A:    w_mag = i_a1 <<< 1;
      PP_3A:    w_mag = i_a3;
      PP_4A:    w_mag = i_a1 <<< 2;
      PP_5A:    w_mag = i_a5;
      PP_6A:    w_mag = i_a3 <<< 1;
      PP_7A:    w_mag = i_a7;
      PP_8A:    w_mag = i_a1 <<< 3;
      PP_not1A: begin w_mag = i_a1;        w_neg = 1'b1; end
      PP_not2A: begin w_mag = i_a1 <<< 1;  w_neg = 1'b1; end
      PP_not3A: begin w_mag = i_a3;        w_neg = 1'b1; end
      PP_not4A: begin w_mag = i_a1 <<< 2;  w_neg = 1'b1; end
      PP_not5A: begin w_mag = i_a5;        w_neg = 1'b1; end
      PP_not6A: begin w_mag = i_a3 <<< 1;  w_neg = 1'b1; end
      PP_not7A: begin w_mag = i_a7;        w_neg = 1'b1; end
      PP_not8A: begin w_mag = i_a1 <<< 3;  w_neg = 1'b1; end
      default:  w_mag = '0;
    endcase
  end

  // WIDTH+4 bits hold +/-8A for both signed and unsigned A, so negation is exact.
  assign o_pp = w_neg ? -w_mag : w_mag;

endmodule

// File: rtl/booth_r16_seq_mul.sv
// Iterative radix-16 Booth multiplier: one multiplier digit per cycle,
// signed or unsigned operands, valid/ready on both sides.
module booth_r16_seq_mul
  import booth_r16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 busy
);

  localparam int N  = WIDTH / 4;
  localparam int PW = WIDTH + 4;
  localparam int AW = 2 * WIDTH + 4;
  localparam int BW = WIDTH + 5;
  localparam int CW = $clog2(N + 2);

  mul_state_t r_state;
  mul_state_t w_state_nxt;

  logic [WIDTH-1:0]      r_a;
  logic [WIDTH-1:0]      r_b;
  logic                  r_sgn;
  logic signed [PW-1:0]  r_a3;
  logic signed [PW-1:0]  r_a5;
  logic signed [PW-1:0]  r_a7;
  logic [BW-1:0]         r_bx;
  logic signed [AW-1:0]  r_acc;
  logic [CW-1:0]         r_cnt;
  logic [2*WIDTH-1:0]    r_out_p;

  logic signed [PW-1:0]  w_a1;
  logic signed [PW-1:0]  w_pp;
  logic signed [AW-1:0]  w_pp_sh;
  logic                  w_bfill;
  logic                  w_last;
  logic [CW-1:0]         w_ndig;
  booth_sel_t            w_sel;

  assign w_a1    = r_sgn ? {{4{r_a[WIDTH-1]}}, r_a} : {4'b0000, r_a};
  assign w_bfill = r_sgn & r_b[WIDTH-1];
  // Unsigned operands need one extra top digit to absorb the multiplier MSB.
  assign w_ndig  = r_sgn ? CW'(N) : CW'(N + 1);
  assign w_last  = (r_cnt == w_ndig);
  assign w_sel   = booth_r16_encode(r_bx[WINDOW_BITS-1:0]);

  booth_r16_pp_sel #(
    .WIDTH (WIDTH)
  ) u_pp_sel (
    .i_sel (w_sel),
    .i_a1  (w_a1),
    .i_a3  (r_a3),
    .i_a5  (r_a5),
    .i_a7  (r_a7),
    .o_pp  (w_pp)
  );

  assign w_pp_sh = {{(AW-PW){w_pp[PW-1]}}, w_pp} << {r_cnt, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_state_nxt = PRECOMP;
      end
      PRECOMP: w_state_nxt = ITER;
      ITER: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sgn   <= 1'b0;
      r_a3    <= '0;
      r_a5    <= '0;
      r_a7    <= '0;
      r_bx    <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_out_p <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a   <= in_a;
            r_b   <= in_b;
            r_sgn <= in_signed;
          end
        end
        PRECOMP: begin
          r_a3  <= (w_a1 <<< 1) + w_a1;
          r_a5  <= (w_a1 <<< 2) + w_a1;
          r_a7  <= (w_a1 <<< 3) - w_a1;
          r_bx  <= {{4{w_bfill}}, r_b, 1'b0};
          r_acc <= '0;
          r_cnt <= '0;
        end
        ITER: begin
          if (w_last) begin
            r_out_p <= r_acc[2*WIDTH-1:0];
          end else begin
            r_acc <= r_acc + w_pp_sh;
            r_cnt <= r_cnt + CW'(1);
            // Shift the next digit window down; bit 4 of the old window becomes the new borrow-in.
            r_bx  <= {{4{w_bfill}}, r_bx[BW-1:4]};
          end
        end
        default: ;
      endcase
    end
  end

  assign out_p = r_out_p;

endmodule
